// File: rtl/calc_sequencer.sv
// calc_sequencer
//   Command sequencer in front of an external combinational ALU. Accepts one
//   command at a time, drives the ALU operands for EXEC_CYCLES clocks, folds
//   the ALU flags into a 2-bit status and holds the response until consumed.
//   Owns a 32-bit accumulator that supplies the P operand.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   cmd_valid/ready   command handshake
//   cmd_op            0 add, 1 sub, 2 mult, 3 div, 4 mod, E load, F clear
//   cmd_operand       Q operand or load value
//   alu_p/q/op        ALU operand/opcode outputs (held outside EXEC)
//   alu_result        ALU result input
//   alu_div_zero      ALU divide-by-zero flag (div or mod)
//   alu_overflow      ALU add/sub overflow flag
//   rsp_valid/ready   response handshake
//   rsp_result        result of the completed command
//   rsp_status        00 ok, 01 div-zero, 10 overflow/range, 11 illegal op
//   acc               accumulator
//   busy              high whenever not IDLE
//
// State | Meaning
// IDLE  | waiting for a command, cmd_ready high
// EXEC  | ALU operands held; result sampled when the down-counter hits zero
// RESP  | response held until rsp_ready
module calc_sequencer #(
  parameter int EXEC_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [15:0] cmd_operand,
  output logic [15:0] alu_p,
  output logic [15:0] alu_q,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_div_zero,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [1:0]  rsp_status,
  output logic [31:0] acc,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } stateT;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_DIV   = 4'h3;
  localparam logic [3:0] OP_MOD   = 4'h4;
  localparam logic [3:0] OP_LOAD  = 4'hE;
  localparam logic [3:0] OP_CLEAR = 4'hF;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_DIVZ  = 2'b01;
  localparam logic [1:0] ST_RANGE = 2'b10;
  localparam logic [1:0] ST_ILL   = 2'b11;

  // Counter is loaded with EXEC_CYCLES-1 so that terminal count (zero)
  // marks the last EXEC cycle.
  localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

  stateT       state, nextState;
  logic [3:0]  execCnt;
  logic        accept;
  logic        isAluOp;
  logic        accFits;
  logic        execDone;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    accept    = 1'b0;
    isAluOp   = (cmd_op <= OP_MOD);
    // The ALU P port is only 16 bits wide; a wider accumulator is a range error.
    accFits   = (acc[31:16] == 16'h0000);
    execDone  = (state == EXEC) && (execCnt == 4'd0);
    cmd_ready = (state == IDLE) && !rst;
    busy      = (state != IDLE);
    rsp_valid = (state == RESP);
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          if (isAluOp && accFits) nextState = EXEC;
          else                    nextState = RESP;
        end
      end
      EXEC: if (execDone) nextState = RESP;
      RESP: if (rsp_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      execCnt    <= 4'd0;
      acc        <= 32'd0;
      rsp_result <= 32'd0;
      rsp_status <= 2'b00;
      alu_p      <= 16'd0;
      alu_q      <= 16'd0;
      alu_op     <= 4'd0;
    end else if (accept) begin
      if (isAluOp) begin
        if (accFits) begin
          alu_p   <= acc[15:0];
          alu_q   <= cmd_operand;
          alu_op  <= cmd_op;
          execCnt <= EXEC_LOAD;
        end else begin
          rsp_status <= ST_RANGE;
          rsp_result <= 32'd0;
        end
      end else if (cmd_op == OP_LOAD) begin
        acc        <= {16'h0000, cmd_operand};
        rsp_result <= {16'h0000, cmd_operand};
        rsp_status <= ST_OK;
      end else if (cmd_op == OP_CLEAR) begin
        acc        <= 32'd0;
        rsp_result <= 32'd0;
        rsp_status <= ST_OK;
      end else begin
        rsp_status <= ST_ILL;
        rsp_result <= 32'd0;
      end
    end else if (state == EXEC) begin
      if (!execDone) begin
        execCnt <= execCnt - 4'd1;
      end else if ((alu_op == OP_DIV || alu_op == OP_MOD) && alu_div_zero) begin
        rsp_status <= ST_DIVZ;
        rsp_result <= 32'd0;
      end else if ((alu_op == OP_ADD || alu_op == OP_SUB) && alu_overflow) begin
        rsp_status <= ST_RANGE;
        rsp_result <= alu_result;
      end else begin
        // Mult ignores the overflow flag; its full 32-bit product is valid.
        rsp_status <= ST_OK;
        rsp_result <= alu_result;
        acc        <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer
//   Directed bench for calc_sequencer (EXEC_CYCLES=2) with a small behavioural
//   ALU model attached to the ALU ports.
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_operand;
  logic [15:0] alu_p;
  logic [15:0] alu_q;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_div_zero;
  logic        alu_overflow;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [1:0]  rsp_status;
  logic [31:0] acc;
  logic        busy;

  int checkCount = 0;
  int failCount  = 0;
  int lat;

  calc_sequencer #(.EXEC_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_operand(cmd_operand),
    .alu_p(alu_p), .alu_q(alu_q), .alu_op(alu_op),
    .alu_result(alu_result), .alu_div_zero(alu_div_zero), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_status(rsp_status),
    .acc(acc), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: add overflows above 16 bits, sub overflows on borrow,
  // mult raises overflow above 16 bits (the sequencer must ignore it).
  always_comb begin
    alu_result   = 32'd0;
    alu_div_zero = 1'b0;
    alu_overflow = 1'b0;
    case (alu_op)
      4'd0: begin
        alu_result   = {16'h0, alu_p} + {16'h0, alu_q};
        alu_overflow = (alu_result[31:16] != 16'h0);
      end
      4'd1: begin
        alu_result   = {16'h0, alu_p} - {16'h0, alu_q};
        alu_overflow = (alu_q > alu_p);
      end
      4'd2: begin
        alu_result   = {16'h0, alu_p} * {16'h0, alu_q};
        alu_overflow = (alu_result[31:16] != 16'h0);
      end
      4'd3: begin
        if (alu_q == 16'h0) alu_div_zero = 1'b1;
        else                alu_result   = {16'h0, alu_p / alu_q};
      end
      4'd4: begin
        if (alu_q == 16'h0) alu_div_zero = 1'b1;
        else                alu_result   = {16'h0, alu_p % alu_q};
      end
      default: ;
    endcase
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sendCmd(input logic [3:0] op, input logic [15:0] operand);
    @(negedge clk);
    checkVal("cmd_ready_idle", cmd_ready, 1);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_operand = operand;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitRsp(output int latency);
    latency = 1;
    while (!rsp_valid && latency < 40) begin
      @(posedge clk);
      #1;
      latency++;
    end
    if (!rsp_valid) checkVal("rsp_timeout", rsp_valid, 1);
  endtask

  task automatic takeRsp;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checkVal("idle_after_rsp", busy, 0);
  endtask

  task automatic runCmd(input string tag, input logic [3:0] op, input logic [15:0] operand,
                        input int expLat, input logic [31:0] expRes,
                        input logic [1:0] expSt, input logic [31:0] expAcc);
    int l;
    sendCmd(op, operand);
    waitRsp(l);
    checkVal({tag, "_lat"}, l, expLat);
    checkVal({tag, "_res"}, rsp_result, expRes);
    checkVal({tag, "_st"}, rsp_status, expSt);
    checkVal({tag, "_acc"}, acc, expAcc);
    takeRsp();
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 4'h0;
    cmd_operand = 16'h0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst_cmd_ready", cmd_ready, 0);
    checkVal("rst_busy", busy, 0);
    checkVal("rst_rsp_valid", rsp_valid, 0);
    checkVal("rst_acc", acc, 0);
    checkVal("rst_alu_p", alu_p, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkVal("rel_cmd_ready", cmd_ready, 1);

    // load 31, mult 3 -> 93
    runCmd("load31", 4'hE, 16'd31, 1, 32'd31, 2'b00, 32'd31);
    sendCmd(4'h2, 16'd3);
    checkVal("mul_alu_p", alu_p, 16'd31);
    checkVal("mul_alu_q", alu_q, 16'd3);
    checkVal("mul_alu_op", alu_op, 4'h2);
    checkVal("mul_busy", busy, 1);
    checkVal("mul_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    checkVal("mul_hold_p", alu_p, 16'd31);
    checkVal("mul_hold_valid", rsp_valid, 0);
    @(posedge clk);
    #1;
    lat = 0;
    waitRsp(lat);
    checkVal("mul_lat", lat + 1, 3);
    checkVal("mul_res", rsp_result, 32'd93);
    checkVal("mul_st", rsp_status, 2'b00);
    checkVal("mul_acc", acc, 32'd93);
    checkVal("mul_keep_p", alu_p, 16'd31);
    takeRsp();

    // sub, overflow, div-zero, mod
    runCmd("load10", 4'hE, 16'd10, 1, 32'd10, 2'b00, 32'd10);
    runCmd("sub3",   4'h1, 16'd3,  3, 32'd7, 2'b00, 32'd7);
    runCmd("sub10",  4'h1, 16'd10, 3, 32'hFFFF_FFFD, 2'b10, 32'd7);
    runCmd("div0",   4'h3, 16'd0,  3, 32'd0, 2'b01, 32'd7);
    runCmd("mod4",   4'h4, 16'd4,  3, 32'd3, 2'b00, 32'd3);

    // illegal op
    runCmd("ill9",   4'h9, 16'd5,  1, 32'd0, 2'b11, 32'd3);

    // range: acc above 16 bits skips EXEC
    runCmd("load300", 4'hE, 16'd300, 1, 32'd300, 2'b00, 32'd300);
    runCmd("mul300",  4'h2, 16'd300, 3, 32'd90000, 2'b00, 32'd90000);
    sendCmd(4'h0, 16'd1);
    waitRsp(lat);
    checkVal("rng_lat", lat, 1);
    checkVal("rng_alu_p_held", alu_p, 16'd300);
    checkVal("rng_alu_op_held", alu_op, 4'h2);

    // response held with rsp_ready low; a command offered meanwhile waits
    cmd_valid   = 1'b1;
    cmd_op      = 4'hE;
    cmd_operand = 16'd77;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkVal("hold_res", rsp_result, 32'd0);
      checkVal("hold_st", rsp_status, 2'b10);
      checkVal("hold_cmd_ready", cmd_ready, 0);
    end
    checkVal("hold_acc", acc, 32'd90000);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checkVal("ret_busy", busy, 0);
    checkVal("ret_cmd_ready", cmd_ready, 1);
    checkVal("ret_acc_not_loaded", acc, 32'd90000);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    checkVal("late_accept_valid", rsp_valid, 1);
    checkVal("late_accept_acc", acc, 32'd77);
    takeRsp();
    runCmd("clear", 4'hF, 16'd9, 1, 32'd0, 2'b00, 32'd0);

    // reset mid-EXEC
    runCmd("load5a", 4'hE, 16'd5, 1, 32'd5, 2'b00, 32'd5);
    sendCmd(4'h0, 16'd2);
    checkVal("pre_rst_busy", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkVal("mid_rst_busy", busy, 0);
    checkVal("mid_rst_valid", rsp_valid, 0);
    checkVal("mid_rst_acc", acc, 0);
    checkVal("mid_rst_alu_op", alu_op, 0);
    checkVal("mid_rst_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkVal("post_rst_cmd_ready", cmd_ready, 1);
    runCmd("load5b", 4'hE, 16'd5, 1, 32'd5, 2'b00, 32'd5);
    runCmd("add2",   4'h0, 16'd2, 3, 32'd7, 2'b00, 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 The block SHALL have parameter EXEC_CYCLES, default 2: number of clock cycles the ALU operands are held stable before the result is sampled, legal range 1..15.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 cmd_valid  in  1  command offered.
REQ-005 cmd_ready  out  1  block can accept a command.
REQ-006 cmd_op  in  4  0=add, 1=sub, 2=mult, 3=div, 4=mod, 4'hE=load, 4'hF=clear; all others illegal.
REQ-007 cmd_operand  in  16  Q operand, or load value for 4'hE.
REQ-008 alu_p  out  16  ALU P operand.
REQ-009 alu_q  out  16  ALU Q operand.
REQ-010 alu_op  out  4  ALU opcode.
REQ-011 alu_result  in  32  ALU output.
REQ-012 alu_div_zero  in  1  OR of the ALU's div and mod divide-by-zero flags.
REQ-013 alu_overflow  in  1  ALU add/sub overflow.
REQ-014 rsp_valid  out  1  response available.
REQ-015 rsp_ready  in  1  consumer accepts response.
REQ-016 rsp_result  out  32  result of the completed command.
REQ-017 rsp_status  out  2  00=ok, 01=divide-by-zero, 10=overflow/range, 11=illegal op.
REQ-018 acc  out  32  accumulator value.
REQ-019 busy  out  1  high in any state other than IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, EXEC and RESP; cmd_ready SHALL equal 1 only in IDLE.
REQ-021 A command SHALL be accepted on a rising edge with cmd_valid=1 in IDLE, and op and operand SHALL be registered on that edge.
REQ-022 For ops 0..4 with acc[31:16]==0, the block SHALL enter EXEC, drive alu_p=acc[15:0], alu_q=operand and alu_op=op, and hold these outputs constant for exactly EXEC_CYCLES cycles.
REQ-023 On the last EXEC cycle the block SHALL sample alu_result and the flags, then enter RESP on the next edge.
REQ-024 Latency from the accept edge to rsp_valid=1 SHALL be EXEC_CYCLES+1 cycles.
REQ-025 For ops 0..4 with acc[31:16]!=0, the block SHALL skip EXEC and enter RESP on the next edge with status 10, result 0, and acc unchanged.
REQ-026 For div or mod with alu_div_zero=1, the block SHALL report status 01 and result 0, with acc unchanged.
REQ-027 For add or sub with alu_overflow=1, the block SHALL report status 10 and result=alu_result, with acc unchanged.
REQ-028 Flags SHALL be checked in this priority order: div-zero, then overflow, then ok; for mult, overflow is ignored.
REQ-029 On status 00, acc SHALL be loaded with alu_result on the edge that enters RESP, and rsp_result SHALL equal the new acc.
REQ-030 Load (4'hE) SHALL set acc={16'b0,operand}, and clear (4'hF) SHALL set acc=0; both SHALL go directly to RESP with status 00 and result equal to the new acc, without driving the ALU.
REQ-031 For an illegal op, the block SHALL go directly to RESP with status 11, result 0, and acc unchanged.
REQ-032 In RESP, rsp_valid SHALL stay 1 and rsp_result/rsp_status SHALL stay stable until rsp_ready=1; the block SHALL return to IDLE on that edge.
REQ-033 A cmd_valid asserted during RESP SHALL NOT be accepted before the cycle after return to IDLE.
REQ-034 Outside EXEC, alu_p, alu_q and alu_op SHALL hold their last driven values.

Reset
REQ-035 On rst=1, all of the following SHALL be cleared immediately, independent of clk: state=IDLE, acc, rsp_result, rsp_status, alu_p, alu_q, alu_op, rsp_valid, busy and the EXEC counter, all set to 0.
REQ-036 cmd_ready SHALL be 0 while rst=1 and 1 on the first cycle after release.
REQ-037 Reset during EXEC or RESP SHALL discard the in-flight command and its response.

Verification
REQ-038 load 31, then op 2 with operand 3 (EXEC_CYCLES=2) -> rsp_valid 3 cycles after accept, result 93, status 00, acc 93.
REQ-039 load 10, then op 1 with operand 3 -> result 7, status 00; op 3 with operand 0 -> status 01, result 0, acc stays 7.
REQ-040 cmd_op=4'h9 -> rsp_valid 1 cycle after accept, status 11, acc unchanged.
REQ-041 load 300, then op 2 with operand 300 (acc=90000), then op 0 with operand 1 -> status 10, result 0, acc stays 90000.
REQ-042 With rsp_ready held 0 for 5 cycles, rsp_result/rsp_status SHALL stay stable and cmd_ready SHALL stay 0; rsp_ready=1 -> IDLE next edge.
REQ-043 Assert rst mid-EXEC -> busy=0, rsp_valid=0, acc=0 immediately, and a new load 5 is accepted after release.
